// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two requester req/rsp channels plus the shared ALU port
interface alu_arbiter_if #(parameter int TAG_WIDTH = 4);
  logic req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [2:0] req_op_0, req_op_1;
  logic [31:0] req_left_0, req_right_0, req_left_1, req_right_1;
  logic [TAG_WIDTH-1:0] req_tag_0, req_tag_1;
  logic rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
  logic [31:0] rsp_result_0, rsp_result_1;
  logic [TAG_WIDTH-1:0] rsp_tag_0, rsp_tag_1;
  logic [2:0] alu_operation;
  logic [31:0] alu_left, alu_right, alu_result;
  modport slave (
    input req_valid_0, req_valid_1, req_op_0, req_op_1,
    input req_left_0, req_right_0, req_left_1, req_right_1, req_tag_0, req_tag_1,
    input rsp_ready_0, rsp_ready_1, alu_result,
    output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
    output rsp_result_0, rsp_result_1, rsp_tag_0, rsp_tag_1,
    output alu_operation, alu_left, alu_right
  );
  modport master (
    output req_valid_0, req_valid_1, req_op_0, req_op_1,
    output req_left_0, req_right_0, req_left_1, req_right_1, req_tag_0, req_tag_1,
    output rsp_ready_0, rsp_ready_1, alu_result,
    input req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
    input rsp_result_0, rsp_result_1, rsp_tag_0, rsp_tag_1,
    input alu_operation, alu_left, alu_right
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters; ALU_ARB_FIXED_PRIORITY_EN makes requester 0 always win ties
module alu_arbiter #(parameter int TAG_WIDTH = 4) (
  input logic clock,
  input logic reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic owner, g0, g1, take, done;
  logic [2:0] op_q;
  logic [31:0] left_q, right_q, result_q;
  logic [TAG_WIDTH-1:0] tag_q;
`ifdef ALU_ARB_FIXED_PRIORITY_EN
  assign g0 = bus.req_valid_0;
`else
  logic last;
  assign g0 = bus.req_valid_0 & (~bus.req_valid_1 | last);
`endif
  assign g1 = bus.req_valid_1 & ~g0;
  assign take = (state == IDLE) & (g0 | g1) & ~reset;
  assign done = (state == RESP) & (owner ? bus.rsp_ready_1 : bus.rsp_ready_0);
  assign bus.req_ready_0 = (state == IDLE) & g0 & ~reset;
  assign bus.req_ready_1 = (state == IDLE) & g1 & ~reset;
  assign bus.alu_operation = op_q;
  assign bus.alu_left = left_q;
  assign bus.alu_right = right_q;
  assign bus.rsp_valid_0 = (state == RESP) & ~owner;
  assign bus.rsp_valid_1 = (state == RESP) & owner;
  assign bus.rsp_result_0 = bus.rsp_valid_0 ? result_q : '0;
  assign bus.rsp_result_1 = bus.rsp_valid_1 ? result_q : '0;
  assign bus.rsp_tag_0 = bus.rsp_valid_0 ? tag_q : '0;
  assign bus.rsp_tag_1 = bus.rsp_valid_1 ? tag_q : '0;
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (take ? EXEC : IDLE) :
              (state == EXEC) ? RESP : (done ? IDLE : RESP);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q <= '0;
      left_q <= '0;
      right_q <= '0;
      tag_q <= '0;
      result_q <= '0;
      owner <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
      last <= 1'b1;
`endif
    end else begin
      if (take) begin
        op_q <= g1 ? bus.req_op_1 : bus.req_op_0;
        left_q <= g1 ? bus.req_left_1 : bus.req_left_0;
        right_q <= g1 ? bus.req_right_1 : bus.req_right_0;
        tag_q <= g1 ? bus.req_tag_1 : bus.req_tag_0;
        owner <= g1;
      end
      if (state == EXEC) result_q <= bus.alu_result;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
      if (done) last <= owner;
`endif
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors with hand-computed results against a behavioural ALU
module tb_alu_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total = 0;
  alu_arbiter_if #(.TAG_WIDTH(4)) bus();
  alu_arbiter #(.TAG_WIDTH(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_operation)
      3'd0: bus.alu_result = bus.alu_left >> bus.alu_right[4:0];
      3'd1: bus.alu_result = $unsigned($signed(bus.alu_left) >>> bus.alu_right[4:0]);
      3'd2: bus.alu_result = {31'd0, $signed(bus.alu_left) < $signed(bus.alu_right)};
      3'd3: bus.alu_result = {31'd0, bus.alu_left < bus.alu_right};
      default: bus.alu_result = '0;
    endcase
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask
  function automatic logic rdy(input int n);
    return n != 0 ? bus.req_ready_1 : bus.req_ready_0;
  endfunction
  function automatic logic rv(input int n);
    return n != 0 ? bus.rsp_valid_1 : bus.rsp_valid_0;
  endfunction
  function automatic logic [31:0] rres(input int n);
    return n != 0 ? bus.rsp_result_1 : bus.rsp_result_0;
  endfunction
  function automatic logic [31:0] rtag(input int n);
    return n != 0 ? {28'd0, bus.rsp_tag_1} : {28'd0, bus.rsp_tag_0};
  endfunction
  task automatic drive(input int n, input logic v, input logic [2:0] op,
                       input logic [31:0] l, input logic [31:0] r, input logic [3:0] t);
    if (n != 0) begin
      bus.req_valid_1 = v; bus.req_op_1 = op; bus.req_left_1 = l; bus.req_right_1 = r; bus.req_tag_1 = t;
    end else begin
      bus.req_valid_0 = v; bus.req_op_0 = op; bus.req_left_0 = l; bus.req_right_0 = r; bus.req_tag_0 = t;
    end
  endtask
  task automatic do_req(input int n, input logic [2:0] op, input logic [31:0] l,
                        input logic [31:0] r, input logic [3:0] t, input logic [31:0] exp);
    @(negedge clock);
    drive(n, 1'b1, op, l, r, t);
    #1 check($sformatf("req%0d_ready", n), 32'(rdy(n)), 32'd1);
    @(negedge clock);
    drive(n, 1'b0, 3'd7, '1, '1, 4'hF);
    #1 check($sformatf("req%0d_exec_valid", n), 32'(rv(n)), 32'd0);
    check($sformatf("req%0d_alu_op", n), 32'(bus.alu_operation), 32'(op));
    check($sformatf("req%0d_alu_left", n), bus.alu_left, l);
    @(negedge clock);
    #1 check($sformatf("rsp%0d_valid", n), 32'(rv(n)), 32'd1);
    check($sformatf("rsp%0d_result_op%0d", n, op), rres(n), exp);
    check($sformatf("rsp%0d_tag", n), rtag(n), 32'(t));
    check($sformatf("rsp%0d_other_valid", n), 32'(rv(1 - n)), 32'd0);
    check($sformatf("rsp%0d_other_result", n), rres(1 - n), 32'd0);
  endtask
  initial begin
    int g;
    drive(0, 1'b0, 3'd0, '0, '0, 4'd0);
    drive(1, 1'b0, 3'd0, '0, '0, 4'd0);
    bus.rsp_ready_0 = 1'b1;
    bus.rsp_ready_1 = 1'b1;
    repeat (2) @(negedge clock);
    #1 check("rst_req_ready_0", 32'(bus.req_ready_0), 32'd0);
    check("rst_req_ready_1", 32'(bus.req_ready_1), 32'd0);
    check("rst_rsp_valid_0", 32'(bus.rsp_valid_0), 32'd0);
    check("rst_rsp_valid_1", 32'(bus.rsp_valid_1), 32'd0);
    check("rst_rsp_result_0", bus.rsp_result_0, 32'd0);
    check("rst_rsp_tag_1", 32'(bus.rsp_tag_1), 32'd0);
    check("rst_alu_op", 32'(bus.alu_operation), 32'd0);
    check("rst_alu_left", bus.alu_left, 32'd0);
    check("rst_alu_right", bus.alu_right, 32'd0);
    reset = 1'b0;
    do_req(0, 3'd0, 32'h8000_0000, 32'd4, 4'd3, 32'h0800_0000);
    do_req(1, 3'd1, 32'h8000_0000, 32'd4, 4'd1, 32'hF800_0000);
    do_req(1, 3'd2, 32'hFFFF_FFFF, 32'd1, 4'd2, 32'd1);
    do_req(1, 3'd3, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd0);
    do_req(1, 3'd5, 32'hFFFF_FFFF, 32'd1, 4'd5, 32'd0);
    // continuous tie: last was requester 1, so requester 0 goes first
    @(negedge clock);
    drive(0, 1'b1, 3'd0, 32'h10, 32'd1, 4'hC);
    drive(1, 1'b1, 3'd3, 32'd1, 32'd2, 4'hD);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
      g = 0;
`else
      g = i % 2;
`endif
      #1 check($sformatf("tie%0d_ready_0", i), 32'(bus.req_ready_0), 32'(g == 0));
      check($sformatf("tie%0d_ready_1", i), 32'(bus.req_ready_1), 32'(g == 1));
      @(negedge clock);
      #1 check($sformatf("tie%0d_exec_ready", i), 32'(bus.req_ready_0 | bus.req_ready_1), 32'd0);
      @(negedge clock);
      #1 check($sformatf("tie%0d_rsp_valid", i), 32'(rv(g)), 32'd1);
      check($sformatf("tie%0d_rsp_result", i), rres(g), g == 0 ? 32'h8 : 32'h1);
      @(negedge clock);
    end
    drive(0, 1'b0, 3'd0, '0, '0, 4'd0);
    drive(1, 1'b0, 3'd0, '0, '0, 4'd0);
    // back-pressure on requester 0 with requester 1 arriving during EXEC
    @(negedge clock);
    bus.rsp_ready_0 = 1'b0;
    drive(0, 1'b1, 3'd0, 32'h100, 32'd4, 4'd9);
    #1 check("bp_ready_0", 32'(bus.req_ready_0), 32'd1);
    @(negedge clock);
    drive(0, 1'b0, 3'd0, '0, '0, 4'd0);
    drive(1, 1'b1, 3'd3, 32'd1, 32'd2, 4'd6);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      #1 check($sformatf("bp%0d_valid", k), 32'(bus.rsp_valid_0), 32'd1);
      check($sformatf("bp%0d_result", k), bus.rsp_result_0, 32'h10);
      check($sformatf("bp%0d_tag", k), 32'(bus.rsp_tag_0), 32'd9);
      check($sformatf("bp%0d_req_ready", k), 32'(bus.req_ready_0 | bus.req_ready_1), 32'd0);
    end
    bus.rsp_ready_0 = 1'b1;
    @(negedge clock);
    #1 check("bp_release_valid", 32'(bus.rsp_valid_0), 32'd0);
    check("bp_release_ready_1", 32'(bus.req_ready_1), 32'd1);
    @(negedge clock);
    drive(1, 1'b0, 3'd0, '0, '0, 4'd0);
    @(negedge clock);
    #1 check("bp_next_valid_1", 32'(bus.rsp_valid_1), 32'd1);
    check("bp_next_result_1", bus.rsp_result_1, 32'd1);
    check("bp_next_tag_1", 32'(bus.rsp_tag_1), 32'd6);
    do_req(0, 3'd2, 32'hFFFF_FFFF, 32'd0, 4'd7, 32'd1);
    // reset while in EXEC; last was requester 0 and must return to 1
    @(negedge clock);
    drive(0, 1'b1, 3'd0, 32'h40, 32'd1, 4'd5);
    #1 check("rx_ready_0", 32'(bus.req_ready_0), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    drive(0, 1'b0, 3'd0, '0, '0, 4'd0);
    @(negedge clock);
    reset = 1'b0;
    #1 check("rx_alu_left", bus.alu_left, 32'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rx%0d_no_rsp", k), 32'(bus.rsp_valid_0 | bus.rsp_valid_1), 32'd0);
      @(negedge clock);
      #1;
    end
    drive(0, 1'b1, 3'd0, 32'h40, 32'd2, 4'hA);
    drive(1, 1'b1, 3'd0, 32'h40, 32'd3, 4'hB);
    #1 check("rx_tie_ready_0", 32'(bus.req_ready_0), 32'd1);
    check("rx_tie_ready_1", 32'(bus.req_ready_1), 32'd0);
    @(negedge clock);
    drive(0, 1'b0, 3'd0, '0, '0, 4'd0);
    drive(1, 1'b0, 3'd0, '0, '0, 4'd0);
    @(negedge clock);
    #1 check("rx_rsp_valid_0", 32'(bus.rsp_valid_0), 32'd1);
    check("rx_rsp_result_0", bus.rsp_result_0, 32'h10);
    check("rx_rsp_tag_0", 32'(bus.rsp_tag_0), 32'hA);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
